// File: rtl/psram_qspi_model_if.sv
// Pin-level bus between a PSRAM controller (master) and the PSRAM device model (slave).
interface psram_qspi_model_if;
   logic       sck;
   logic       ce_n;
   logic [3:0] dio_i;
   logic [3:0] dio_o;
   logic [3:0] dio_oe;
   logic       qpi_mode;
   logic       err;

   modport master (output sck, ce_n, dio_i, input dio_o, dio_oe, qpi_mode, err);
   modport slave  (input sck, ce_n, dio_i, output dio_o, dio_oe, qpi_mode, err);
endinterface

// File: rtl/psram_qspi_model.sv
// PSRAM device model oversampling sck/ce_n/dio in the system clock domain; SPI and quad read/write.
// Optional QPI enter/exit commands (0x35/0xF5) are built when PSRAM_QPI_EN is defined.
module psram_qspi_model #(
   parameter int MEM_AW      = 16,
   parameter int PAGE_AW     = 10,
   parameter int WAIT_CYCLES = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clock,
   input  logic               reset,
   psram_qspi_model_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, READ, WRITE, ERR} state_t;

   localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'((1 << PAGE_AW) - 1);

   logic       sck_sync_reg [SYNC_STAGES];
   logic       ce_sync_reg  [SYNC_STAGES];
   logic [3:0] dio_sync_reg [SYNC_STAGES];
   logic       sck_d_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sck_sync_reg[i] <= 1'b0;
            ce_sync_reg[i]  <= 1'b1;
            dio_sync_reg[i] <= 4'h0;
         end
         sck_d_reg <= 1'b0;
      end else begin
         sck_sync_reg[0] <= bus.sck;
         ce_sync_reg[0]  <= bus.ce_n;
         dio_sync_reg[0] <= bus.dio_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sck_sync_reg[i] <= sck_sync_reg[i-1];
            ce_sync_reg[i]  <= ce_sync_reg[i-1];
            dio_sync_reg[i] <= dio_sync_reg[i-1];
         end
         sck_d_reg <= sck_sync_reg[SYNC_STAGES-1];
      end
   end

   logic       sck_s, ce_s, sck_rise, sck_fall;
   logic [3:0] din;
   assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
   assign ce_s     = ce_sync_reg[SYNC_STAGES-1];
   assign din      = dio_sync_reg[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d_reg;
   assign sck_fall = ~sck_s & sck_d_reg;

   // Byte array with registered read; the FSM issues registered read/write requests.
   logic [7:0]        mem [2**MEM_AW];
   logic              we_reg, re_reg;
   logic [MEM_AW-1:0] waddr_reg, raddr_reg;
   logic [7:0]        wdata_reg, rdata_reg;

   always_ff @(posedge clock) begin
      if (we_reg)
         mem[waddr_reg] <= wdata_reg;
      if (re_reg)
         rdata_reg <= mem[raddr_reg];
   end

   function automatic logic [MEM_AW-1:0] page_next(input logic [MEM_AW-1:0] a);
      return (a & ~PAGE_MASK) | ((a + 1'b1) & PAGE_MASK);
   endfunction

   state_t            state_reg;
   logic [4:0]        cnt_reg;
   logic [2:0]        pos_reg;
   logic [23:0]       shift_reg, shift_next;
   logic [MEM_AW-1:0] addr_reg, addr_in;
   logic              quad_reg, rd_cmd_reg, wait_cmd_reg;
   logic [7:0]        cur_reg;
   logic [3:0]        dio_o_reg, dio_oe_reg;
   logic              err_reg, qpi, qbus;

`ifdef PSRAM_QPI_EN
   logic qpi_mode_reg, qpi_set_reg, qpi_clr_reg;
   assign qpi = qpi_mode_reg;
`else
   assign qpi = 1'b0;
`endif

   always_comb begin
      qbus       = (state_reg == CMD) ? qpi : quad_reg;
      shift_next = qbus ? {shift_reg[19:0], din} : {shift_reg[22:0], din[0]};
      addr_in    = MEM_AW'(shift_next);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         pos_reg      <= '0;
         shift_reg    <= '0;
         addr_reg     <= '0;
         quad_reg     <= 1'b0;
         rd_cmd_reg   <= 1'b0;
         wait_cmd_reg <= 1'b0;
         cur_reg      <= '0;
         dio_o_reg    <= '0;
         dio_oe_reg   <= '0;
         err_reg      <= 1'b0;
         we_reg       <= 1'b0;
         re_reg       <= 1'b0;
         waddr_reg    <= '0;
         wdata_reg    <= '0;
         raddr_reg    <= '0;
`ifdef PSRAM_QPI_EN
         qpi_mode_reg <= 1'b0;
         qpi_set_reg  <= 1'b0;
         qpi_clr_reg  <= 1'b0;
`endif
      end else begin
         err_reg <= 1'b0;
         we_reg  <= 1'b0;
         re_reg  <= 1'b0;
         if (ce_s) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            pos_reg    <= '0;
            dio_oe_reg <= '0;
`ifdef PSRAM_QPI_EN
            if (qpi_set_reg)
               qpi_mode_reg <= 1'b1;
            else if (qpi_clr_reg)
               qpi_mode_reg <= 1'b0;
            qpi_set_reg <= 1'b0;
            qpi_clr_reg <= 1'b0;
`endif
         end else begin
            case (state_reg)
               IDLE: begin
                  state_reg <= CMD;
                  cnt_reg   <= '0;
               end
               CMD: if (sck_rise) begin
                  shift_reg <= shift_next;
                  if (cnt_reg == (qpi ? 5'd1 : 5'd7)) begin
                     cnt_reg <= '0;
                     case (shift_next[7:0])
                        8'hEB: begin
                           state_reg <= ADDR; quad_reg <= 1'b1; rd_cmd_reg <= 1'b1; wait_cmd_reg <= 1'b1;
                        end
                        8'h38: begin
                           state_reg <= ADDR; quad_reg <= 1'b1; rd_cmd_reg <= 1'b0; wait_cmd_reg <= 1'b0;
                        end
                        8'h03, 8'h02: begin
                           if (qpi) begin
                              state_reg <= ERR;
                              err_reg   <= 1'b1;
                           end else begin
                              state_reg    <= ADDR;
                              quad_reg     <= 1'b0;
                              rd_cmd_reg   <= (shift_next[7:0] == 8'h03);
                              wait_cmd_reg <= 1'b0;
                           end
                        end
`ifdef PSRAM_QPI_EN
                        // Mode commands park in ERR silently; the mode flips when ce_n rises.
                        8'h35: begin
                           state_reg   <= ERR;
                           qpi_set_reg <= 1'b1;
                        end
                        8'hF5: begin
                           state_reg <= ERR;
                           if (qpi)
                              qpi_clr_reg <= 1'b1;
                           else
                              err_reg <= 1'b1;
                        end
`endif
                        default: begin
                           state_reg <= ERR;
                           err_reg   <= 1'b1;
                        end
                     endcase
                  end else begin
                     cnt_reg <= cnt_reg + 5'd1;
                  end
               end
               ADDR: if (sck_rise) begin
                  shift_reg <= shift_next;
                  if (cnt_reg == (quad_reg ? 5'd5 : 5'd23)) begin
                     cnt_reg <= '0;
                     pos_reg <= '0;
                     if (rd_cmd_reg && (!wait_cmd_reg || WAIT_CYCLES == 0)) begin
                        state_reg  <= READ;
                        re_reg     <= 1'b1;
                        raddr_reg  <= addr_in;
                        addr_reg   <= page_next(addr_in);
                        dio_oe_reg <= quad_reg ? 4'hF : 4'h2;
                     end else begin
                        state_reg <= wait_cmd_reg ? WAIT : WRITE;
                        addr_reg  <= addr_in;
                     end
                  end else begin
                     cnt_reg <= cnt_reg + 5'd1;
                  end
               end
               WAIT: if (sck_rise) begin
                  if (cnt_reg == 5'(WAIT_CYCLES - 1)) begin
                     state_reg  <= READ;
                     re_reg     <= 1'b1;
                     raddr_reg  <= addr_reg;
                     addr_reg   <= page_next(addr_reg);
                     dio_oe_reg <= quad_reg ? 4'hF : 4'h2;
                     cnt_reg    <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 5'd1;
                  end
               end
               // addr_reg always points at the next byte to prefetch.
               READ: if (sck_fall) begin
                  if (pos_reg == 3'd0) begin
                     cur_reg   <= rdata_reg;
                     dio_o_reg <= quad_reg ? rdata_reg[7:4] : {2'b00, rdata_reg[7], 1'b0};
                     re_reg    <= 1'b1;
                     raddr_reg <= addr_reg;
                     addr_reg  <= page_next(addr_reg);
                  end else begin
                     dio_o_reg <= quad_reg ? cur_reg[3:0] : {2'b00, cur_reg[3'd7 - pos_reg], 1'b0};
                  end
                  pos_reg <= quad_reg ? {2'b00, ~pos_reg[0]} : pos_reg + 3'd1;
               end
               WRITE: if (sck_rise) begin
                  shift_reg <= shift_next;
                  if (pos_reg == (quad_reg ? 3'd1 : 3'd7)) begin
                     pos_reg   <= '0;
                     we_reg    <= 1'b1;
                     waddr_reg <= addr_reg;
                     wdata_reg <= shift_next[7:0];
                     addr_reg  <= page_next(addr_reg);
                  end else begin
                     pos_reg <= pos_reg + 3'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.dio_o    = dio_o_reg;
   assign bus.dio_oe   = dio_oe_reg;
   assign bus.err      = err_reg;
   assign bus.qpi_mode = qpi;
endmodule

// File: tb/tb_psram_qspi_model.sv
// Directed bench for psram_qspi_model: bit-banged controller, model memory and expected-byte queue.
module tb_psram_qspi_model;
   localparam int HP = 60;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   psram_qspi_model_if bus();

   psram_qspi_model #(.MEM_AW(16), .PAGE_AW(10), .WAIT_CYCLES(6), .SYNC_STAGES(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int err_cnt = 0;
   int base;
   logic [7:0] model [int];
   logic [7:0] sb_q [$];

   always @(posedge clock) if (bus.err === 1'b1) err_cnt <= err_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int nxt(input int a);
      return (a & ~32'h3FF) | ((a + 1) & 32'h3FF);
   endfunction

   task automatic xfer(input logic [3:0] d, output logic [3:0] q);
      bus.dio_i = d;
      #HP;
      q = bus.dio_o;
      bus.sck = 1'b1;
      #HP;
      bus.sck = 1'b0;
   endtask

   task automatic tx_spi(input logic [7:0] b);
      logic [3:0] q;
      for (int i = 7; i >= 0; i--) xfer({3'b000, b[i]}, q);
   endtask

   task automatic tx_quad(input logic [7:0] b);
      logic [3:0] q;
      xfer(b[7:4], q);
      xfer(b[3:0], q);
   endtask

   task automatic tx_addr(input logic [23:0] a, input bit quad);
      for (int i = 2; i >= 0; i--) begin
         if (quad) tx_quad(a[i*8 +: 8]);
         else      tx_spi(a[i*8 +: 8]);
      end
   endtask

   task automatic dummy(input int n);
      logic [3:0] q;
      for (int i = 0; i < n; i++) xfer(4'h0, q);
   endtask

   task automatic begin_tx();
      bus.ce_n = 1'b0;
      #100;
   endtask

   task automatic end_tx();
      #HP;
      bus.ce_n = 1'b1;
      #200;
   endtask

   task automatic push_read(input int a, input int n);
      for (int k = 0; k < n; k++) begin
         sb_q.push_back(model[a]);
         a = nxt(a);
      end
   endtask

   task automatic rx_byte(input string tag, input bit quad);
      logic [7:0] b;
      logic [7:0] exp;
      logic [3:0] q;
      if (quad) begin
         xfer(4'h0, q); b[7:4] = q;
         xfer(4'h0, q); b[3:0] = q;
      end else begin
         for (int i = 7; i >= 0; i--) begin
            xfer(4'h0, q);
            b[i] = q[1];
         end
      end
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      check(tag, {24'h0, b}, {24'h0, exp});
      check({tag, "_oe"}, {28'h0, bus.dio_oe}, quad ? 32'hF : 32'h2);
      $display("rx %s data=%02h exp=%02h oe=%h", tag, b, exp, bus.dio_oe);
   endtask

   task automatic wr_bytes(input logic [7:0] cmd, input int a, input logic [7:0] d [], input bit quad);
      begin_tx();
      tx_spi(cmd);
      tx_addr(24'(a), quad);
      foreach (d[k]) begin
         if (quad) tx_quad(d[k]);
         else      tx_spi(d[k]);
         model[a] = d[k];
         a = nxt(a);
      end
      end_tx();
      $display("wr cmd=%02h bytes=%0d", cmd, d.size());
   endtask

   task automatic rd_bytes(input string tag, input logic [7:0] cmd, input int a, input int n);
      bit quad;
      quad = (cmd == 8'hEB);
      begin_tx();
      tx_spi(cmd);
      tx_addr(24'(a), quad);
      if (quad) dummy(6);
      push_read(a, n);
      for (int k = 0; k < n; k++) rx_byte(tag, quad);
      end_tx();
      check({tag, "_oe_idle"}, {28'h0, bus.dio_oe}, 32'h0);
   endtask

   initial begin
      logic [7:0] d2 [];
      logic [7:0] d4 [];
      bus.sck = 1'b0; bus.ce_n = 1'b1; bus.dio_i = 4'h0;
      #52;
      check("rst_dio_o", {28'h0, bus.dio_o}, 32'h0);
      check("rst_dio_oe", {28'h0, bus.dio_oe}, 32'h0);
      check("rst_err", {31'h0, bus.err}, 32'h0);
      check("rst_qpi", {31'h0, bus.qpi_mode}, 32'h0);
      reset = 1'b0;
      #50;

      d2 = '{8'hA5, 8'h3C};
      wr_bytes(8'h02, 32'h10, d2, 1'b0);
      rd_bytes("spi_rd", 8'h03, 32'h10, 2);

      d4 = '{8'h11, 8'h22, 8'h33, 8'h44};
      wr_bytes(8'h38, 32'h100, d4, 1'b1);
      rd_bytes("quad_rd", 8'hEB, 32'h100, 4);

      d4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      wr_bytes(8'h38, 32'h3FE, d4, 1'b1);
      rd_bytes("wrap_rd", 8'hEB, 32'h3FE, 4);
      rd_bytes("wrap_low", 8'h03, 32'h000, 2);

      d2 = '{8'h55, 8'h66};
      wr_bytes(8'h02, 32'h200, d2, 1'b0);
      begin_tx();
      tx_spi(8'h38);
      tx_addr(24'h000200, 1'b1);
      tx_quad(8'h99);
      dummy(1);
      end_tx();
      model[32'h200] = 8'h99;
      rd_bytes("partial", 8'h03, 32'h200, 2);

      base = err_cnt;
      begin_tx();
      tx_spi(8'h9F);
      tx_spi(8'h00);
      tx_spi(8'hFF);
      check("err_oe", {28'h0, bus.dio_oe}, 32'h0);
      end_tx();
      check("err_pulse", err_cnt - base, 1);
      rd_bytes("after_err", 8'hEB, 32'h100, 1);

      base = err_cnt;
      begin_tx();
      tx_spi(8'h35);
      end_tx();
`ifdef PSRAM_QPI_EN
      check("qpi_on", {31'h0, bus.qpi_mode}, 32'h1);
      check("qpi_no_err", err_cnt - base, 0);
      begin_tx();
      tx_quad(8'hEB);
      tx_addr(24'h000100, 1'b1);
      dummy(6);
      push_read(32'h100, 1);
      rx_byte("qpi_rd", 1'b1);
`else
      check("qpi_off", {31'h0, bus.qpi_mode}, 32'h0);
      check("qpi_cmd_err", err_cnt - base, 1);
      begin_tx();
      tx_spi(8'hEB);
      tx_addr(24'h000100, 1'b1);
      dummy(6);
      push_read(32'h100, 1);
      rx_byte("pre_rst_rd", 1'b1);
`endif
      reset = 1'b1;
      #10;
      check("midrst_oe", {28'h0, bus.dio_oe}, 32'h0);
      #10;
      check("midrst_qpi", {31'h0, bus.qpi_mode}, 32'h0);
      reset = 1'b0;
      end_tx();
      rd_bytes("post_rst", 8'hEB, 32'h10, 1);
      check("sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
